mask_modulator: RTL and testbench

//  M-level amplitude-shift-keying modulator, generalising 1-bit on/off ASK. Accepts

---
 rtl/mask_modulator.sv | 196 +++++++++++++++++++
 tb/tb_mask_modulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mask_modulator.sv
// M-level ASK modulator: buffered symbol stream in, signed square-wave carrier
// scaled to the symbol's amplitude level out, one sample per sample_en tick.
module mask_modulator #(
    parameter int DATA_W          = 8,
    parameter int BITS_PER_SYM    = 2,
    parameter int SAMPLES_PER_SYM = 4,
    parameter int PHASE_W         = 8,
    parameter int STEP            = 40,
    parameter int GRAY            = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_en,
    input  logic [PHASE_W-1:0]      phase_inc,
    input  logic                    sym_valid,
    input  logic [BITS_PER_SYM-1:0] sym_data,
    output logic                    sym_ready,
    output logic [DATA_W-1:0]       out_sample,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    underrun
);

    localparam int CNT_W = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);
    localparam logic [DATA_W-1:0] STEP_V   = DATA_W'(STEP);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nx_s;
    logic [PHASE_W-1:0]      phase_r;
    logic                    buf_full_r;
    logic [BITS_PER_SYM-1:0] buf_data_r;
    logic [BITS_PER_SYM-1:0] cur_level_r;
    logic [BITS_PER_SYM-1:0] new_level_s;
    logic [BITS_PER_SYM-1:0] level_sel_s;
    logic [DATA_W-1:0]       amp_s;
    logic [DATA_W-1:0]       sample_s;
    logic                    load_s;
    logic                    underrun_s;
    logic                    emit_zero_s;
    logic                    accept_s;
    logic [DATA_W-1:0]       out_sample_r;
    logic                    out_valid_r;
    logic                    underrun_r;

    function automatic logic [BITS_PER_SYM-1:0] gray2bin(input logic [BITS_PER_SYM-1:0] g);
        logic [BITS_PER_SYM-1:0] b;
        b = g;
        for (int i = BITS_PER_SYM - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [BITS_PER_SYM-1:0] sym_to_level(input logic [BITS_PER_SYM-1:0] s);
        if (GRAY != 0) begin
            return gray2bin(s);
        end else begin
            return s;
        end
    endfunction

    // Parameter constraint guarantees (M-1)*STEP fits the positive signed range.
    function automatic logic [DATA_W-1:0] amp_of(input logic [BITS_PER_SYM-1:0] lvl);
        return DATA_W'(lvl) * STEP_V;
    endfunction

    assign sym_ready   = ~buf_full_r & ~reset;
    assign accept_s    = sym_valid & sym_ready;
    assign new_level_s = sym_to_level(buf_data_r);
    assign out_sample  = out_sample_r;
    assign out_valid   = out_valid_r;
    assign underrun    = underrun_r;
    assign busy        = (state_r == ACTIVE);

    // FSM state register and symbol sample counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic: everything holds unless a sample tick arrives
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        load_s      = 1'b0;
        underrun_s  = 1'b0;
        emit_zero_s = 1'b1;
        if (sample_en) begin
            case (state_r)
                IDLE: begin
                    if (buf_full_r) begin
                        load_s      = 1'b1;
                        cnt_nx_s    = '0;
                        state_nx_s  = ACTIVE;
                        emit_zero_s = 1'b0;
                    end else begin
                        state_nx_s  = IDLE;
                    end
                end
                ACTIVE: begin
                    if (cnt_r != CNT_LAST) begin
                        cnt_nx_s    = cnt_r + CNT_W'(1);
                        emit_zero_s = 1'b0;
                    end else if (buf_full_r) begin
                        load_s      = 1'b1;
                        cnt_nx_s    = '0;
                        emit_zero_s = 1'b0;
                    end else begin
                        state_nx_s  = IDLE;
                        cnt_nx_s    = '0;
                        underrun_s  = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = '0;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Output logic: a loading tick already uses the freshly loaded level
    always_comb begin
        level_sel_s = load_s ? new_level_s : cur_level_r;
        amp_s       = amp_of(level_sel_s);
        if (emit_zero_s) begin
            sample_s = '0;
        end else if (phase_r[PHASE_W-1]) begin
            sample_s = -amp_s;
        end else begin
            sample_s = amp_s;
        end
    end

    // Carrier phase accumulator; the current tick's sample uses the pre-add phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= '0;
        end else if (sample_en) begin
            phase_r <= phase_r + phase_inc;
        end
    end

    // One-entry holding buffer; ready is low while full, so load and accept never coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full_r <= 1'b0;
            buf_data_r <= '0;
        end else if (load_s) begin
            buf_full_r <= 1'b0;
        end else if (accept_s) begin
            buf_full_r <= 1'b1;
            buf_data_r <= sym_data;
        end
    end

    // Level of the symbol currently on air
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_level_r <= '0;
        end else if (load_s) begin
            cur_level_r <= new_level_s;
        end
    end

    // Registered sample outputs; out_sample holds between ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sample_r <= '0;
            out_valid_r  <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            out_valid_r <= sample_en;
            underrun_r  <= underrun_s;
            if (sample_en) begin
                out_sample_r <= sample_s;
            end
        end
    end

endmodule

// File: tb/tb_mask_modulator.sv
// Randomised and directed bench for mask_modulator, checked against a symbol-level
// reference model (binary and Gray-decoded instances driven by the same stream).
module tb_mask_modulator;
    localparam int DW = 8, BPS = 2, SPS = 4, PW = 8, STEP = 40;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  sample_en;
    logic [PW-1:0]         phase_inc;
    logic                  sym_valid;
    logic [BPS-1:0]        sym_data;
    logic                  sym_ready, out_valid, busy, underrun;
    logic signed [DW-1:0]  out_sample;
    logic                  sym_ready_g, out_valid_g, busy_g, underrun_g;
    logic signed [DW-1:0]  out_sample_g;

    mask_modulator #(.DATA_W(DW), .BITS_PER_SYM(BPS), .SAMPLES_PER_SYM(SPS),
                     .PHASE_W(PW), .STEP(STEP), .GRAY(0)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .phase_inc(phase_inc),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .out_sample(out_sample), .out_valid(out_valid), .busy(busy), .underrun(underrun));

    mask_modulator #(.DATA_W(DW), .BITS_PER_SYM(BPS), .SAMPLES_PER_SYM(SPS),
                     .PHASE_W(PW), .STEP(STEP), .GRAY(1)) dut_g (
        .clk(clk), .reset(reset), .sample_en(sample_en), .phase_inc(phase_inc),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready_g),
        .out_sample(out_sample_g), .out_valid(out_valid_g), .busy(busy_g), .underrun(underrun_g));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int tx_q[$];

    // Reference model state: symbol-level view of the stream
    int  m_phase = 0, m_left = 0, m_sym = 0;
    bit  m_active = 0, m_acc = 0;
    int  m_bufq[$];
    int  e_sample = 0, e_sample_g = 0;
    bit  e_valid = 0, e_under = 0;

    function automatic int gray_level(input int g);
        int b = 0;
        for (int s = g; s != 0; s = s >> 1) b = b ^ s;
        return b;
    endfunction

    function automatic int carrier(input int level, input int phase);
        int a = level * STEP;
        return (phase >= (1 << (PW - 1))) ? -a : a;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit rdy;
        if (reset) begin
            m_phase = 0; m_left = 0; m_sym = 0; m_active = 0; m_acc = 0;
            m_bufq.delete();
            e_sample = 0; e_sample_g = 0; e_valid = 0; e_under = 0;
        end else begin
            rdy     = (m_bufq.size() == 0);
            m_acc   = sym_valid && rdy;
            e_valid = sample_en;
            e_under = 0;
            if (sample_en) begin
                if (m_left > 0) begin
                    m_left--;
                end else if (m_bufq.size() > 0) begin
                    m_sym    = m_bufq.pop_front();
                    m_left   = SPS - 1;
                    m_active = 1;
                end else begin
                    e_under  = m_active;
                    m_active = 0;
                end
                e_sample   = m_active ? carrier(m_sym, m_phase) : 0;
                e_sample_g = m_active ? carrier(gray_level(m_sym), m_phase) : 0;
                m_phase    = (m_phase + int'(phase_inc)) % (1 << PW);
            end
            if (m_acc) m_bufq.push_back(int'(sym_data));
        end
    end

    // Advance one clock: offer the head of tx_q, then retire it if the model saw it accepted.
    task automatic step(input bit se);
        sym_valid = (tx_q.size() > 0);
        sym_data  = (tx_q.size() > 0) ? BPS'(tx_q[0]) : '0;
        sample_en = se;
        @(posedge clk);
        #1;
        if (m_acc && tx_q.size() > 0) void'(tx_q.pop_front());
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1);
            n_checks++;
            if (sym_ready !== 1'b0) $display("FAIL rst ready_in_reset: got %b want 0", sym_ready); else n_pass++;
            n_checks++;
            if (out_sample !== 8'sd0 || out_valid !== 1'b0) $display("FAIL rst outputs: got %0d/%b want 0/0", out_sample, out_valid); else n_pass++;
        end
        reset = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step(c % 2 == 0);
            n_checks++;
            if (out_sample !== 8'sd0) $display("FAIL idle sample: got %0d want 0", out_sample); else n_pass++;
            n_checks++;
            if (busy !== 1'b0 || underrun !== 1'b0) $display("FAIL idle busy/underrun: got %b/%b want 0/0", busy, underrun); else n_pass++;
            n_checks++;
            if (sym_ready !== 1'b1 || out_valid !== e_valid) $display("FAIL idle ready/valid: got %b/%b want 1/%b", sym_ready, out_valid, e_valid); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        phase_inc = 8'd64;
        tx_q.push_back(3);
        tx_q.push_back(1);
        for (int c = 0; c < 28; c++) begin
            step(c % 2 == 0);
            n_checks++;
            if (int'(out_sample) !== e_sample) $display("FAIL b2b sample: got %0d want %0d", out_sample, e_sample); else n_pass++;
            n_checks++;
            if (busy !== m_active || underrun !== e_under) $display("FAIL b2b busy/underrun: got %b/%b want %b/%b", busy, underrun, m_active, e_under); else n_pass++;
            n_checks++;
            if (sym_ready !== (m_bufq.size() == 0) || out_valid !== e_valid) $display("FAIL b2b ready/valid: got %b/%b want %b/%b", sym_ready, out_valid, m_bufq.size() == 0, e_valid); else n_pass++;
        end
    endtask

    task automatic test_gray();
        phase_inc = 8'd64;
        tx_q.push_back(2);
        for (int c = 0; c < 16; c++) begin
            step(c % 2 == 0);
            n_checks++;
            if (int'(out_sample) !== e_sample) $display("FAIL gray0 sample: got %0d want %0d", out_sample, e_sample); else n_pass++;
            n_checks++;
            if (int'(out_sample_g) !== e_sample_g) $display("FAIL gray1 sample: got %0d want %0d", out_sample_g, e_sample_g); else n_pass++;
            n_checks++;
            if (busy_g !== m_active || underrun_g !== e_under) $display("FAIL gray1 busy/underrun: got %b/%b want %b/%b", busy_g, underrun_g, m_active, e_under); else n_pass++;
        end
    endtask

    task automatic test_streaming();
        int mags = 0;
        for (int k = 0; k < 4; k++) tx_q.push_back(2);
        for (int c = 0; c < 40; c++) begin
            step(c % 2 == 0);
            if (c % 2 == 0 && (out_sample == 8'sd80 || out_sample == -8'sd80)) mags++;
            n_checks++;
            if (int'(out_sample) !== e_sample) $display("FAIL stream sample: got %0d want %0d", out_sample, e_sample); else n_pass++;
            n_checks++;
            if (busy !== m_active || underrun !== e_under) $display("FAIL stream busy/underrun: got %b/%b want %b/%b", busy, underrun, m_active, e_under); else n_pass++;
            n_checks++;
            if (sym_ready !== (m_bufq.size() == 0)) $display("FAIL stream ready: got %b want %b", sym_ready, m_bufq.size() == 0); else n_pass++;
        end
        n_checks++;
        if (mags !== 16) $display("FAIL stream magnitude_count: got %0d want 16", mags); else n_pass++;
    endtask

    task automatic test_reset_mid();
        phase_inc = 8'd64;
        for (int k = 0; k < 3; k++) tx_q.push_back(3);
        for (int c = 0; c < 9; c++) step(c % 2 == 0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_sample !== 8'sd0 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid outputs: got %0d/%b/%b want 0/0/0", out_sample, out_valid, busy); else n_pass++;
        n_checks++;
        if (sym_ready !== 1'b0) $display("FAIL rstmid ready: got %b want 0", sym_ready); else n_pass++;
        tx_q.delete();
        step(1'b1);
        step(1'b0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(c % 2 == 0);
            n_checks++;
            if (out_sample !== 8'sd0 || busy !== 1'b0 || underrun !== 1'b0) $display("FAIL rstmid stale: got %0d/%b/%b want 0/0/0", out_sample, busy, underrun); else n_pass++;
        end
        tx_q.push_back(1);
        for (int c = 0; c < 14; c++) begin
            step(c % 2 == 0);
            n_checks++;
            if (int'(out_sample) !== e_sample) $display("FAIL rstmid phase_restart: got %0d want %0d", out_sample, e_sample); else n_pass++;
        end
    endtask

    task automatic test_phase_dc();
        phase_inc = 8'd0;
        tx_q.push_back(1);
        tx_q.push_back(1);
        for (int c = 0; c < 20; c++) begin
            if (c == 8) phase_inc = 8'd128;
            step(c % 2 == 0);
            n_checks++;
            if (int'(out_sample) !== e_sample) $display("FAIL phase sample: got %0d want %0d", out_sample, e_sample); else n_pass++;
            n_checks++;
            if (busy !== m_active || underrun !== e_under) $display("FAIL phase busy/underrun: got %b/%b want %b/%b", busy, underrun, m_active, e_under); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (tx_q.size() == 0 && $urandom_range(0, 3) != 0) tx_q.push_back(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 40) == 0) phase_inc = PW'($urandom);
            step($urandom_range(0, 2) == 0);
            n_checks++;
            if (int'(out_sample) !== e_sample) $display("FAIL rand sample: got %0d want %0d", out_sample, e_sample); else n_pass++;
            n_checks++;
            if (int'(out_sample_g) !== e_sample_g) $display("FAIL rand sample_gray: got %0d want %0d", out_sample_g, e_sample_g); else n_pass++;
            n_checks++;
            if (busy !== m_active || underrun !== e_under || out_valid !== e_valid) $display("FAIL rand busy/underrun/valid: got %b/%b/%b want %b/%b/%b", busy, underrun, out_valid, m_active, e_under, e_valid); else n_pass++;
            n_checks++;
            if (sym_ready !== (m_bufq.size() == 0)) $display("FAIL rand ready: got %b want %b", sym_ready, m_bufq.size() == 0); else n_pass++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        sym_valid = 1'b0;
        sym_data  = '0;
        phase_inc = 8'd64;
        test_reset();
        test_back_to_back();
        test_gray();
        test_streaming();
        test_reset_mid();
        test_phase_dc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
